// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined WIDTH-bit add/subtract with segmented carry chain and valid/ready flow control
//
// Purpose:
//   The carry chain is cut into STAGES equal segments of SEG = WIDTH/STAGES bits.
//   Stage k adds slice k of A and B' plus the carry registered by stage k-1.
//   Operands, partial sums, the carry and the valid bit travel together down the pipe.
//   A single global enable moves every stage at once, so a stalled output holds the whole pipe.
//
// Optional feature:
//   ADDER_PIPE_SAT_EN - when defined, the final stage clamps Sum to signed max/min on
//   overflow (chosen by the sign of A). Cout and Ovf are reported unchanged.
//   When undefined, Sum wraps modulo 2^WIDTH.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted this cycle (combinational, equals pipeline enable)
//   A, B       in   WIDTH-bit operands
//   Cin        in   carry in, add mode only
//   sub        in   0: A+B+Cin, 1: A-B
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result beat
//   Sum        out  WIDTH-bit result
//   Cout       out  carry out of top segment (sub mode: 1 = no borrow)
//   Ovf        out  signed two's-complement overflow

module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    generate
        if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
            $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
        end
    endgenerate

    // Stage registers: index k holds the state leaving stage k.
    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic                         ovf_q, ovf_d;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Chains prepend the pipe inputs so stage k always reads index k,
    // including stage 0, without any k-1 indexing.
    logic [STAGES:0]            v_chain;
    logic [STAGES:0]            c_chain;
    logic [STAGES:0][WIDTH-1:0] a_chain;
    logic [STAGES:0][WIDTH-1:0] b_chain;
    logic [STAGES:0][WIDTH-1:0] s_chain;

    // Temporaries for one segment of the carry chain.
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] part_sum;

    assign en       = !v_q[LAST] || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1, so Cin is ignored in sub mode.
    assign b_eff = sub ? ~B : B;
    assign c0    = sub | Cin;

    assign v_chain = {v_q, in_valid};
    assign c_chain = {c_q, c0};
    assign a_chain = {a_q, A};
    assign b_chain = {b_q, b_eff};
    assign s_chain = {s_q, {WIDTH{1'b0}}};

    always_comb begin
        v_d      = v_q;
        c_d      = c_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        ovf_d    = ovf_q;
        seg_sum  = '0;
        part_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_chain[k][k*SEG +: SEG]}
                    + {1'b0, b_chain[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_chain[k]};
            part_sum               = s_chain[k];
            part_sum[k*SEG +: SEG] = seg_sum[SEG-1:0];
            v_d[k] = v_chain[k];
            c_d[k] = seg_sum[SEG];
            a_d[k] = a_chain[k];
            b_d[k] = b_chain[k];
            s_d[k] = part_sum;
        end
        // Overflow uses the operand signs carried alongside the final stage and
        // the unclamped sum it has just completed.
        ovf_d = (a_chain[LAST][WIDTH-1] == b_chain[LAST][WIDTH-1])
             && (s_d[LAST][WIDTH-1] != a_chain[LAST][WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (ovf_d) begin
            s_d[LAST] = a_chain[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign Sum       = s_q[LAST];
    assign Cout      = c_q[LAST];
    assign Ovf       = ovf_q;

    // The chain entries past the final stage have no consumer.
    logic unused_chain_top;
    assign unused_chain_top = ^{v_chain[STAGES], c_chain[STAGES], a_chain[STAGES],
                                b_chain[STAGES], s_chain[STAGES]};

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe against an arithmetic reference model

module tb_adder_pipe;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         Cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout, Ovf;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         lit;
        logic [W-1:0] lsum;
        logic         lcout;
        logic         lovf;
    } res_t;

    int vecs = 0;
    int errs = 0;

    // Literal expectations attached to the beat currently being offered.
    logic         lit_en   = 1'b0;
    logic [W-1:0] lit_sum  = '0;
    logic         lit_cout = 1'b0;
    logic         lit_ovf  = 1'b0;

    // Slot model: S result slots, advancing whenever the consumer can take the head.
    bit   mv[S];
    res_t md[S];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s);
        res_t   r;
        longint sa, sb, sr;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!s) begin
            u      = 64'(a) + 64'(b) + 64'(cin);
            sr     = sa + sb + longint'(cin);
            r.cout = u[W];
        end else begin
            u      = 64'(a) - 64'(b);
            sr     = sa - sb;
            r.cout = (a >= b);
        end
        r.sum = u[W-1:0];
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADDER_PIPE_SAT_EN
        if (r.ovf) r.sum = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        r.lit   = 1'b0;
        r.lsum  = '0;
        r.lcout = 1'b0;
        r.lovf  = 1'b0;
        return r;
    endfunction

    always @(negedge clk) begin
        bit   en_m;
        res_t nr;
        if (!rst_n) begin
            for (int k = 0; k < S; k++) mv[k] = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            en_m = !mv[S-1] || out_ready;
            chk("in_ready", 64'(in_ready), 64'(en_m));
            chk("out_valid", 64'(out_valid), 64'(mv[S-1]));
            if (mv[S-1] && out_valid) begin
                chk("sum", 64'(Sum), 64'(md[S-1].sum));
                chk("cout", 64'(Cout), 64'(md[S-1].cout));
                chk("ovf", 64'(Ovf), 64'(md[S-1].ovf));
                if (md[S-1].lit) begin
                    chk("lit_sum", 64'(Sum), 64'(md[S-1].lsum));
                    chk("lit_cout", 64'(Cout), 64'(md[S-1].lcout));
                    chk("lit_ovf", 64'(Ovf), 64'(md[S-1].lovf));
                end
            end
            if (en_m) begin
                for (int k = S-1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    md[k] = md[k-1];
                end
                nr       = model(A, B, Cin, sub);
                nr.lit   = lit_en;
                nr.lsum  = lit_sum;
                nr.lcout = lit_cout;
                nr.lovf  = lit_ovf;
                mv[0]    = in_valid;
                md[0]    = nr;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic le, input logic [W-1:0] ls,
                        input logic lc, input logic lo);
        bit acc;
        A = a; B = b; Cin = c; sub = s;
        lit_en = le; lit_sum = ls; lit_cout = lc; lit_ovf = lo;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        lit_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [W-1:0] sat_pos_sum, sat_neg_sum;

    initial begin
`ifdef ADDER_PIPE_SAT_EN
        sat_pos_sum = 32'h7FFF_FFFF;
        sat_neg_sum = 32'h8000_0000;
`else
        sat_pos_sum = 32'h8000_0000;
        sat_neg_sum = 32'h7FFF_FFFF;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        #1;
        chk("reset_sum", 64'(Sum), 64'd0);
        chk("reset_cout", 64'(Cout), 64'd0);
        chk("reset_ovf", 64'(Ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Carry ripple, overflow, subtract with borrow.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, sat_pos_sum, 1'b0, 1'b1);
        send(32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, sat_neg_sum, 1'b1, 1'b1);
        idle(8);

        // Backpressure: six back-to-back beats, stall three cycles at the first result.
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(W'(i), W'(i), 1'b0, 1'b0, 1'b1, W'(2*i), 1'b0, 1'b0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                if (!seen) chk("bp_first_out_timeout", 64'd0, 64'd1);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(10);

        // Carry-in, two bubbles, then a mid-width carry.
        send(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        idle(2);
        send(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 32'h0001_FFFE, 1'b0, 1'b0);
        idle(8);

        // Reset mid-flight between clock edges.
        send(32'd11, 32'd22, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        send(32'd3, 32'd9, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(Sum), 64'd0);
        chk("midrst_cout", 64'(Cout), 64'd0);
        chk("midrst_ovf", 64'(Ovf), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);

        // Randomized traffic with random backpressure.
        repeat (600) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            A         = rand_op();
            B         = rand_op();
            Cin       = $urandom_range(0, 1);
            sub       = $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
